sdram_arbiter: RTL and testbench

//  Shares the single SDRAM controller between a video fetch port (read-only), a CPU port
//  (read/write) and an internal periodic refresh timer. The SDRAM controller is driven

---
 rtl/sdram_arbiter_if.sv | 31 +++
 rtl/sdram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Request/strobe bundle between the machine's requesters, the arbiter and the SDRAM controller.
// vReq/cReq are levels held until the one-cycle vAck/cAck; the requester drops them the cycle after.
interface sdram_arbiter_if;
  logic        sdReady;
  logic        sdRefresh;
  logic        sdWrite;
  logic        sdRead;
  logic [23:0] sdA;
  logic [15:0] sdD;
  logic [15:0] sdQ;
  logic        vReq;
  logic [23:0] vA;
  logic [15:0] vQ;
  logic        vAck;
  logic        cReq;
  logic        cWe;
  logic [23:0] cA;
  logic [15:0] cD;
  logic [15:0] cQ;
  logic        cAck;

  modport slave (
    input  sdReady, sdQ, vReq, vA, cReq, cWe, cA, cD,
    output sdRefresh, sdWrite, sdRead, sdA, sdD, vQ, vAck, cQ, cAck
  );

  modport master (
    output sdReady, sdQ, vReq, vA, cReq, cWe, cA, cD,
    input  sdRefresh, sdWrite, sdRead, sdA, sdD, vQ, vAck, cQ, cAck
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Time-slot arbiter sharing one SDRAM controller between video reads, CPU accesses and refresh.
// Each slot: pulse one strobe, hold sdA/sdD, capture sdQ at slot end, then ack the owner.
module sdram_arbiter #(
  parameter int REFRESH_PERIOD = 512,
  parameter int STROBE_LEN     = 2,
  parameter int SLOT_LEN       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  sdram_arbiter_if.slave        bus,
  output logic [1:0]            dbg_state
);
  localparam int RW   = $clog2(REFRESH_PERIOD);
  localparam int CMAX = (STROBE_LEN > SLOT_LEN) ? STROBE_LEN : SLOT_LEN;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] OWN_V = 2'd0;
  localparam logic [1:0] OWN_C = 2'd1;
  localparam logic [1:0] OWN_R = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic          last_v_q, last_v_d;
  logic [1:0]    owner_q, owner_d;
  logic          we_q, we_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          rf_q, rf_d;
  logic [23:0]   sd_a_q, sd_a_d;
  logic [15:0]   sd_d_q, sd_d_d;
  logic [15:0]   v_q_q, v_q_d;
  logic [15:0]   c_q_q, c_q_d;
  logic          v_ack_q, v_ack_d;
  logic          c_ack_q, c_ack_d;

  logic wrap;
  logic grant_ref;
  logic start;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_cnt_d = ref_cnt_q;
    last_v_d  = last_v_q;
    owner_d   = owner_q;
    we_d      = we_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rf_d      = rf_q;
    sd_a_d    = sd_a_q;
    sd_d_d    = sd_d_q;
    v_q_d     = v_q_q;
    c_q_d     = c_q_q;
    v_ack_d   = 1'b0;
    c_ack_d   = 1'b0;
    grant_ref = 1'b0;
    start     = 1'b0;

    // Refresh timebase only runs once the controller has finished init.
    wrap = bus.sdReady && (ref_cnt_q == RW'(REFRESH_PERIOD - 1));
    if (bus.sdReady) ref_cnt_d = wrap ? '0 : ref_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.sdReady) begin
          if (ref_pend_q) begin
            grant_ref = 1'b1;
            start     = 1'b1;
            owner_d   = OWN_R;
            we_d      = 1'b0;
            rf_d      = 1'b1;
            sd_a_d    = '0;
          end else if (bus.vReq && (!bus.cReq || !last_v_q)) begin
            start    = 1'b1;
            owner_d  = OWN_V;
            we_d     = 1'b0;
            rd_d     = 1'b1;
            sd_a_d   = bus.vA;
            last_v_d = 1'b1;
          end else if (bus.cReq) begin
            start    = 1'b1;
            owner_d  = OWN_C;
            we_d     = bus.cWe;
            wr_d     = bus.cWe;
            rd_d     = !bus.cWe;
            sd_a_d   = bus.cA;
            if (bus.cWe) sd_d_d = bus.cD;
            last_v_d = 1'b0;
          end
          if (start) begin
            state_d = S_STROBE;
            cnt_d   = '0;
          end
        end
      end
      S_STROBE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(STROBE_LEN - 1)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          rf_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SLOT_LEN - 1)) begin
          state_d = S_DONE;
          if (owner_q == OWN_V) v_q_d = bus.sdQ;
          if (owner_q == OWN_C && !we_q) c_q_d = bus.sdQ;
          v_ack_d = (owner_q == OWN_V);
          c_ack_d = (owner_q == OWN_C);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A wrap in the same cycle as a refresh grant starts a fresh pending request.
    ref_pend_d = wrap | (ref_pend_q & ~grant_ref);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      last_v_q   <= 1'b0;
      owner_q    <= OWN_V;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rf_q       <= 1'b0;
      sd_a_q     <= '0;
      sd_d_q     <= '0;
      v_q_q      <= '0;
      c_q_q      <= '0;
      v_ack_q    <= 1'b0;
      c_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      last_v_q   <= last_v_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rf_q       <= rf_d;
      sd_a_q     <= sd_a_d;
      sd_d_q     <= sd_d_d;
      v_q_q      <= v_q_d;
      c_q_q      <= c_q_d;
      v_ack_q    <= v_ack_d;
      c_ack_q    <= c_ack_d;
    end
  end

  assign bus.sdRefresh = rf_q;
  assign bus.sdWrite   = wr_q;
  assign bus.sdRead    = rd_q;
  assign bus.sdA       = sd_a_q;
  assign bus.sdD       = sd_d_q;
  assign bus.vQ        = v_q_q;
  assign bus.vAck      = v_ack_q;
  assign bus.cQ        = c_q_q;
  assign bus.cAck      = c_ack_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus randomized traffic, checked against
// slot-timing rules, a grant-order model and a reference memory.
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  int cyc = 0;

  sdram_arbiter_if ifc ();

  sdram_arbiter dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (ifc),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference memories ----------------
  logic [15:0] sd_mem  [logic [23:0]];
  logic [15:0] ref_mem [logic [23:0]];
  logic [15:0] last_cq = '0;

  function automatic logic [15:0] init_val(input logic [23:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] sd_rd(input logic [23:0] a);
    if (sd_mem.exists(a)) return sd_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [23:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  // ---------------- SDRAM side monitor / controller model ----------------
  localparam int ACK_N = 18;  // strobe first seen at n=0, ack in the DONE cycle
  bit          busy = 0;
  int          g_cyc, last_grant_cyc = 0, ref_cyc = 0;
  logic [2:0]  g_kind;
  logic [23:0] g_a;
  logic [15:0] g_d;
  bit          g_v, g_ref, last_v_m = 0;
  bit          p_v, p_c, p_we, p_rdy;
  logic [23:0] p_va, p_ca;
  logic [15:0] p_cd;
  int          n_ref = 0, n_data = 0, n_vack = 0, n_cack = 0;
  logic [0:0]  own_q[$];
  logic [0:0]  exp_q[$];

  always @(negedge clk) begin : mon
    logic [2:0] strb;
    int n;
    bit exp_v;
    strb = {ifc.sdRefresh, ifc.sdWrite, ifc.sdRead};
    if (rst) begin
      busy     = 0;
      last_v_m = 0;
      ifc.sdQ  = 16'($urandom);
    end else begin
      chk("strobe_excl", 64'($countones(strb) <= 1), 1);
      if (!busy && strb != 3'b000) begin
        busy = 1; g_cyc = cyc; g_kind = strb; g_a = ifc.sdA; g_d = ifc.sdD;
        chk("grant_ready", p_rdy, 1);
        if (strb == 3'b100) begin
          g_ref = 1; g_v = 0; n_ref++; ref_cyc = cyc;
          chk("ref_addr", ifc.sdA, 0);
        end else begin
          g_ref = 0; n_data++; last_grant_cyc = cyc;
          chk("grant_has_req", p_v | p_c, 1);
          exp_v = (p_v && p_c) ? !last_v_m : p_v;
          g_v = exp_v;
          last_v_m = exp_v;
          own_q.push_back(exp_v);
          chk("grant_addr", ifc.sdA, exp_v ? p_va : p_ca);
          chk("grant_kind", strb, (!exp_v && p_we) ? 3'b010 : 3'b001);
          if (!exp_v && p_we) chk("grant_wdata", ifc.sdD, p_cd);
        end
      end
      if (busy) begin
        n = cyc - g_cyc;
        chk("strobe_len", strb, (n < 2) ? g_kind : 3'b000);
        chk("addr_hold", ifc.sdA, g_a);
        chk("data_hold", ifc.sdD, g_d);
        if (g_kind == 3'b010 && n == 2) sd_mem[g_a] = g_d;
        chk("vack", ifc.vAck, (n == ACK_N) && !g_ref && g_v);
        chk("cack", ifc.cAck, (n == ACK_N) && !g_ref && !g_v);
        // Read data is only meaningful in the last slot cycle; garbage elsewhere.
        if (n == ACK_N - 1 && g_kind == 3'b001) ifc.sdQ = sd_rd(g_a);
        else ifc.sdQ = 16'($urandom);
        if (n == ACK_N) busy = 0;
      end else begin
        chk("vack_idle", ifc.vAck, 0);
        chk("cack_idle", ifc.cAck, 0);
        ifc.sdQ = 16'($urandom);
      end
      if (ifc.vAck) n_vack++;
      if (ifc.cAck) n_cack++;
    end
    p_v = ifc.vReq; p_c = ifc.cReq; p_we = ifc.cWe; p_rdy = ifc.sdReady;
    p_va = ifc.vA; p_ca = ifc.cA; p_cd = ifc.cD;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic v_start(input logic [23:0] a);
    ifc.vA = a; ifc.vReq = 1'b1;
  endtask

  task automatic v_finish(input logic [23:0] a, output logic [15:0] q, output int ack_cyc);
    int t = 0;
    q = '0; ack_cyc = -1;
    while (t < 3000) begin
      @(negedge clk);
      if (ifc.vAck) break;
      t++;
    end
    chk("v_ack_timeout", t < 3000, 1);
    if (t < 3000) begin
      q = ifc.vQ; ack_cyc = cyc;
      chk("v_rd_data", ifc.vQ, ref_rd(a));
    end
    @(posedge clk); #1;
    ifc.vReq = 1'b0; ifc.vA = 24'($urandom);
  endtask

  task automatic c_start(input logic we, input logic [23:0] a, input logic [15:0] d);
    ifc.cWe = we; ifc.cA = a; ifc.cD = d; ifc.cReq = 1'b1;
  endtask

  task automatic c_finish(input logic we, input logic [23:0] a, input logic [15:0] d,
                          output logic [15:0] q, output int ack_cyc);
    int t = 0;
    q = '0; ack_cyc = -1;
    while (t < 3000) begin
      @(negedge clk);
      if (ifc.cAck) break;
      t++;
    end
    chk("c_ack_timeout", t < 3000, 1);
    if (t < 3000) begin
      q = ifc.cQ; ack_cyc = cyc;
      if (we) begin
        chk("c_wr_q_hold", ifc.cQ, last_cq);
        ref_mem[a] = d;
      end else begin
        chk("c_rd_data", ifc.cQ, ref_rd(a));
        last_cq = ref_rd(a);
      end
    end
    @(posedge clk); #1;
    ifc.cReq = 1'b0; ifc.cA = 24'($urandom); ifc.cD = 16'($urandom); ifc.cWe = 1'($urandom);
  endtask

  task automatic wait_ref();
    int start = n_ref;
    int t = 0;
    while (n_ref == start && t < 2000) begin @(posedge clk); #1; t++; end
    chk("ref_timeout", n_ref != start, 1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_strobes"}, {ifc.sdRefresh, ifc.sdWrite, ifc.sdRead}, 0);
    chk({pfx, "_sdA"}, ifc.sdA, 0);
    chk({pfx, "_sdD"}, ifc.sdD, 0);
    chk({pfx, "_vQ"}, ifc.vQ, 0);
    chk({pfx, "_cQ"}, ifc.cQ, 0);
    chk({pfx, "_acks"}, {ifc.vAck, ifc.cAck}, 0);
  endtask

  // ---------------- stimulus ----------------
  bit v_done, c_done;

  initial begin : main
    logic [15:0] q;
    int ac, bd, nr, nv0, nc0, rc, x;
    ifc.sdReady = 1'b1; ifc.vReq = 1'b0; ifc.vA = '0;
    ifc.cReq = 1'b0; ifc.cWe = 1'b0; ifc.cA = '0; ifc.cD = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;

    // 1: CPU write
    c_start(1'b1, 24'h000123, 16'hBEEF);
    c_finish(1'b1, 24'h000123, 16'hBEEF, q, ac);
    chk("t1_lat", ac - (last_grant_cyc - 1), 19);
    chk("t1_mem", sd_rd(24'h000123), 16'hBEEF);

    // 2: CPU read back
    nv0 = n_vack;
    c_start(1'b0, 24'h000123, 16'h0000);
    c_finish(1'b0, 24'h000123, 16'h0000, q, ac);
    chk("t2_cq", q, 16'hBEEF);
    chk("t2_no_vack", n_vack - nv0, 0);

    // 3: simultaneous requests alternate
    own_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      fork
        begin : vb
          logic [15:0] vq; int vac;
          v_start(24'h000050 + 24'(i)); v_finish(24'h000050 + 24'(i), vq, vac);
        end
        begin : cb
          logic [15:0] cq; int cac;
          c_start(1'b0, 24'h000123, 16'h0); c_finish(1'b0, 24'h000123, 16'h0, cq, cac);
        end
      join
    end
    chk("t3_grants", own_q.size(), 8);
    while (exp_q.size() > 0 && own_q.size() > 0) chk("t3_order", own_q.pop_front(), exp_q.pop_front());

    // random traffic with sdReady toggling
    v_done = 0; c_done = 0;
    fork
      begin : rv
        logic [15:0] rq; int rac; logic [23:0] ra;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
          ra = 24'h000040 + 24'($urandom_range(0, 7));
          v_start(ra); v_finish(ra, rq, rac);
        end
        v_done = 1;
      end
      begin : rcpu
        logic [15:0] rq, rd; int rac; logic [23:0] ra; logic rw;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
          ra = 24'h000040 + 24'($urandom_range(0, 7));
          rw = ($urandom_range(0, 2) == 0);
          rd = 16'($urandom);
          c_start(rw, ra, rd); c_finish(rw, ra, rd, rq, rac);
        end
        c_done = 1;
      end
      begin : rrdy
        while (!(v_done && c_done)) begin
          @(posedge clk); #1;
          ifc.sdReady = ($urandom_range(0, 7) != 0);
        end
        ifc.sdReady = 1'b1;
      end
    join

    // 4: refresh periodicity and priority over video
    wait_ref();
    wait_ref();
    rc = ref_cyc; nr = n_ref; bd = n_data;
    wait_cyc(rc + 511);
    v_start(24'h000123);
    v_finish(24'h000123, q, ac);
    chk("t4_one_ref", n_ref - nr, 1);
    chk("t4_ref_cyc", ref_cyc, rc + 512);
    chk("t4_v_grant", last_grant_cyc, rc + 532);
    chk("t4_v_count", n_data - bd, 1);

    // 5: sdReady low blocks grants
    bd = n_data; nr = n_ref;
    ifc.sdReady = 1'b0;
    v_start(24'h000123);
    repeat (100) begin @(posedge clk); #1; end
    chk("t5_no_grant", (n_data - bd) + (n_ref - nr), 0);
    ifc.sdReady = 1'b1;
    x = cyc;
    v_finish(24'h000123, q, ac);
    chk("t5_grant_cyc", last_grant_cyc, x + 1);
    chk("t5_vq", q, ref_rd(24'h000123));

    // 6: reset during the slot of a CPU read
    bd = n_data;
    c_start(1'b0, 24'h000041, 16'h0);
    x = 0;
    while (n_data == bd && x < 100) begin @(posedge clk); #1; x++; end
    chk("t6_granted", n_data != bd, 1);
    wait_cyc(last_grant_cyc + 6);
    rst = 1'b1; ifc.cReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_cq = '0;
    nc0 = n_cack;
    @(negedge clk);
    chk_reset_outputs("t6");
    repeat (40) @(posedge clk);
    #1;
    chk("t6_no_cack", n_cack - nc0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
